// File: rtl/vc_fifo.sv
// vc_fifo: N_VC independent virtual-channel FIFOs that share one write port
// and one read port.
//
// Each VC has SLOTS entries and its own write and read pointers. Every pointer
// carries one extra wrap bit, so a VC can tell full from empty by comparing its
// two pointers.
//
// Optional feature: define VC_FIFO_BYPASS_EN to enable same-cycle
// write-to-read bypass on an empty VC. Without the macro that case stores the
// flit and reports the empty read as an error.
//
// Access semantics (no backpressure, single-cycle requests):
//   write_i=1 pushes data_i into VC wr_vc_i at the next clk edge, unless that VC
//   is full; a write to a full VC is dropped and error_o is raised for the cycle.
//   read_i=1 pops the head of VC rd_vc_i at the next clk edge, unless that VC is
//   empty; a read of an empty VC changes nothing and raises error_o.
//   data_o always shows the current head of VC rd_vc_i, or zero when that VC is
//   empty. All flags are evaluated on pre-edge state.
module vc_fifo #(
  parameter int N_VC      = 2,
  parameter int SLOTS     = 4,
  parameter int WIDTH     = 8,
  parameter int AFULL_THR = SLOTS - 1
) (
  input  logic                                clk,
  input  logic                                arst,
  input  logic                                write_i,
  input  logic [$clog2(N_VC)-1:0]             wr_vc_i,
  input  logic [WIDTH-1:0]                    data_i,
  input  logic                                read_i,
  input  logic [$clog2(N_VC)-1:0]             rd_vc_i,
  output logic [WIDTH-1:0]                    data_o,
  output logic [N_VC-1:0]                     full_o,
  output logic [N_VC-1:0]                     empty_o,
  output logic [N_VC-1:0]                     afull_o,
  output logic [N_VC*($clog2(SLOTS)+1)-1:0]   ocup_o,
  output logic                                error_o
);

  localparam int VW = $clog2(N_VC);
  localparam int AW = $clog2(SLOTS);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_P = PW'(AFULL_THR);

  logic [WIDTH-1:0] mem_q    [N_VC][SLOTS];
  logic [PW-1:0]    wr_ptr_q [N_VC];
  logic [PW-1:0]    rd_ptr_q [N_VC];
  logic [PW-1:0]    wr_ptr_d [N_VC];
  logic [PW-1:0]    rd_ptr_d [N_VC];

  logic wr_full;
  logic rd_empty;
  logic bypass;
  logic do_write;
  logic do_read;

  // Per-VC status flags derived purely from the two pointers
  always_comb begin
    full_o  = '0;
    empty_o = '0;
    afull_o = '0;
    ocup_o  = '0;
    for (int v = 0; v < N_VC; v++) begin
      empty_o[v]          = (wr_ptr_q[v] == rd_ptr_q[v]);
      full_o[v]           = (wr_ptr_q[v][AW-1:0] == rd_ptr_q[v][AW-1:0]) &&
                            (wr_ptr_q[v][AW] != rd_ptr_q[v][AW]);
      ocup_o[v*PW +: PW]  = wr_ptr_q[v] - rd_ptr_q[v];
      afull_o[v]          = (ocup_o[v*PW +: PW] >= AFULL_P);
    end
  end

  // Qualify requests against pre-edge flags and detect the bypass case
  always_comb begin
    wr_full  = full_o[wr_vc_i];
    rd_empty = empty_o[rd_vc_i];
`ifdef VC_FIFO_BYPASS_EN
    bypass   = write_i && read_i && (wr_vc_i == rd_vc_i) && rd_empty;
`else
    bypass   = 1'b0;
`endif
    do_write = write_i && !wr_full && !bypass;
    do_read  = read_i && !rd_empty;
    error_o  = (write_i && wr_full) || (read_i && rd_empty && !bypass);
  end

  // Head-of-queue output, with the bypassed flit taking priority
  always_comb begin
    if (bypass) begin
      data_o = data_i;
    end else if (rd_empty) begin
      data_o = '0;
    end else begin
      data_o = mem_q[rd_vc_i][rd_ptr_q[rd_vc_i][AW-1:0]];
    end
  end

  // Next-state pointers; only the addressed VC moves
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_write) begin
      wr_ptr_d[wr_vc_i] = wr_ptr_q[wr_vc_i] + PW'(1);
    end
    if (do_read) begin
      rd_ptr_d[rd_vc_i] = rd_ptr_q[rd_vc_i] + PW'(1);
    end
  end

  // Pointer registers, cleared immediately by the asynchronous reset
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int v = 0; v < N_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
      end
    end else begin
      for (int v = 0; v < N_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
      end
    end
  end

  // Flit storage: written at the target VC's write pointer, cleared on reset
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int v = 0; v < N_VC; v++) begin
        for (int s = 0; s < SLOTS; s++) begin
          mem_q[v][s] <= '0;
        end
      end
    end else if (do_write) begin
      mem_q[wr_vc_i][wr_ptr_q[wr_vc_i][AW-1:0]] <= data_i;
    end
  end

endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: randomized and directed stimulus for vc_fifo with default
// parameters (2 VCs, 4 slots, 8-bit flits, almost-full at 3). Expected
// outputs come from a queue-per-VC reference model. Honours
// VC_FIFO_BYPASS_EN the same way the design does.
module tb_vc_fifo;

  localparam int N_VC  = 2;
  localparam int SLOTS = 4;
  localparam int WIDTH = 8;
  localparam int AFULL = SLOTS - 1;

  logic             clk;
  logic             arst;
  logic             write_i;
  logic [0:0]       wr_vc_i;
  logic [WIDTH-1:0] data_i;
  logic             read_i;
  logic [0:0]       rd_vc_i;
  logic [WIDTH-1:0] data_o;
  logic [N_VC-1:0]  full_o;
  logic [N_VC-1:0]  empty_o;
  logic [N_VC-1:0]  afull_o;
  logic [5:0]       ocup_o;
  logic             error_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue of flits per VC
  logic [WIDTH-1:0] model_q [N_VC][$];

  vc_fifo #(.N_VC(N_VC), .SLOTS(SLOTS), .WIDTH(WIDTH), .AFULL_THR(AFULL)) dut (
    .clk     (clk),
    .arst    (arst),
    .write_i (write_i),
    .wr_vc_i (wr_vc_i),
    .data_i  (data_i),
    .read_i  (read_i),
    .rd_vc_i (rd_vc_i),
    .data_o  (data_o),
    .full_o  (full_o),
    .empty_o (empty_o),
    .afull_o (afull_o),
    .ocup_o  (ocup_o),
    .error_o (error_o)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every status output against the model's current contents
  task automatic check_flags(input string tag);
    logic [N_VC-1:0] e_full, e_empty, e_afull;
    logic [5:0]      e_ocup;
    e_full = '0; e_empty = '0; e_afull = '0; e_ocup = '0;
    for (int v = 0; v < N_VC; v++) begin
      e_full[v]        = (model_q[v].size() == SLOTS);
      e_empty[v]       = (model_q[v].size() == 0);
      e_afull[v]       = (model_q[v].size() >= AFULL);
      e_ocup[v*3 +: 3] = 3'(model_q[v].size());
    end
    check({tag, ".full"},  32'(full_o),  32'(e_full));
    check({tag, ".empty"}, 32'(empty_o), 32'(e_empty));
    check({tag, ".afull"}, 32'(afull_o), 32'(e_afull));
    check({tag, ".ocup"},  32'(ocup_o),  32'(e_ocup));
  endtask

  // Apply one cycle of requests (entered and left at negedge), check the
  // combinational outputs before the edge, then update the model
  task automatic cycle(input logic w, input logic [0:0] wv, input logic [WIDTH-1:0] d,
                       input logic r, input logic [0:0] rv);
    logic             wfull, rempty, byp, e_err, do_w, do_r;
    logic [WIDTH-1:0] e_data;
    write_i = w; wr_vc_i = wv; data_i = d; read_i = r; rd_vc_i = rv;
    #1;
    wfull  = (model_q[wv].size() == SLOTS);
    rempty = (model_q[rv].size() == 0);
`ifdef VC_FIFO_BYPASS_EN
    byp = w && r && (wv == rv) && rempty;
`else
    byp = 1'b0;
`endif
    e_err  = (w && wfull) || (r && rempty && !byp);
    e_data = byp ? d : (rempty ? '0 : model_q[rv][0]);
    do_w   = w && !wfull && !byp;
    do_r   = r && !rempty;
    check_flags("cyc");
    check("data_o", 32'(data_o), 32'(e_data));
    check("error_o", 32'(error_o), 32'(e_err));
    @(posedge clk);
    if (do_r) void'(model_q[rv].pop_front());
    if (do_w) model_q[wv].push_back(d);
    @(negedge clk);
    write_i = 1'b0; read_i = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    arst = 1'b1; write_i = 1'b0; wr_vc_i = '0; data_i = '0; read_i = 1'b0; rd_vc_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check_flags("rst");
    check("rst.data_o", 32'(data_o), 32'h0);
    check("rst.error_o", 32'(error_o), 32'h0);
    arst = 1'b0;
    @(negedge clk);

    // First write becomes visible one cycle later
    cycle(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
    idle();
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Fill VC1, overflow it, then drain in order
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Fill VC0, then alternate reads and writes so the pointers wrap
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 8'(8'h30 + i), 1'b0, 1'b0);
    end

    // VC0 is full: simultaneous read and write pops but drops 0x55
    cycle(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Same-cycle write and read on empty VC1
    cycle(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    idle();
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Randomized traffic, biased towards writes then reads to visit full/empty
    for (int i = 0; i < 400; i++) begin
      int wbias;
      wbias = ((i / 50) % 2 == 0) ? 70 : 30;
      cycle(($urandom_range(99) < wbias), 1'($urandom_range(1)), 8'($urandom),
            ($urandom_range(99) >= wbias), 1'($urandom_range(1)));
    end

    // Asynchronous reset mid-operation with 3 flits queued in VC0
    while (model_q[0].size() > 0) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
    idle();
    #2;
    arst = 1'b1;
    #1;
    for (int v = 0; v < N_VC; v++) model_q[v].delete();
    check_flags("arst");
    check("arst.data_o", 32'(data_o), 32'h0);
    @(negedge clk);
    arst = 1'b0;
    cycle(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
